// File: rtl/mux_arb.sv
// rtl/mux_arb.sv - N-channel registered mux with external-select or round-robin grant
// Optional packet lock (grant held until last beat) enabled by `define MUX_ARB_PKT_LOCK_EN
module mux_arb #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_vld,
  input  logic [NCH*WIDTH-1:0] in_dat,
  output logic [NCH-1:0]       in_rdy,
`ifdef MUX_ARB_PKT_LOCK_EN
  input  logic [NCH-1:0]       in_lst,
  output logic                 out_lst,
`endif
  output logic                 out_vld,
  output logic [WIDTH-1:0]     out_dat,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_rdy
);

  logic [SELW-1:0]  ptr;
  logic [NCH-1:0]   grant;
  logic             found;
  logic             load_en;
  logic             xfer;
  logic [SELW-1:0]  gidx;
  logic [WIDTH-1:0] gdat;
`ifdef MUX_ARB_PKT_LOCK_EN
  logic             lock;
  logic [SELW-1:0]  lock_ch;
  logic             glst;
`endif

  assign load_en = !out_vld || out_rdy;

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (!mode) begin
      for (int i = 0; i < NCH; i++)
        if (sel == SELW'(i)) grant[i] = in_vld[i];
    end else begin
      // Candidate k steps past ptr, so ptr itself is searched last.
      for (int k = 1; k <= NCH; k++) begin
        for (int i = 0; i < NCH; i++) begin
          if (!found && in_vld[i] &&
              ((int'(ptr) + k == i) || (int'(ptr) + k - NCH == i))) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end
`ifdef MUX_ARB_PKT_LOCK_EN
    if (lock) begin
      grant = '0;
      for (int i = 0; i < NCH; i++)
        if (lock_ch == SELW'(i)) grant[i] = in_vld[i];
    end
`endif
  end

  always_comb begin
    gidx = '0;
    gdat = '0;
`ifdef MUX_ARB_PKT_LOCK_EN
    glst = 1'b0;
`endif
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        gidx = SELW'(i);
        gdat = in_dat[i*WIDTH +: WIDTH];
`ifdef MUX_ARB_PKT_LOCK_EN
        glst = in_lst[i];
`endif
      end
    end
  end

  assign in_rdy = rst ? '0 : (grant & {NCH{load_en}});
  assign xfer   = |in_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      out_ch  <= '0;
      ptr     <= SELW'(NCH - 1);
`ifdef MUX_ARB_PKT_LOCK_EN
      out_lst <= 1'b0;
      lock    <= 1'b0;
      lock_ch <= '0;
`endif
    end else if (xfer) begin
      out_vld <= 1'b1;
      out_dat <= gdat;
      out_ch  <= gidx;
`ifdef MUX_ARB_PKT_LOCK_EN
      out_lst <= glst;
      lock    <= !glst;
      lock_ch <= gidx;
      if (mode && glst) ptr <= gidx;
`else
      if (mode) ptr <= gidx;
`endif
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb.sv
// tb/tb_mux_arb.sv - directed self-checking bench for mux_arb (NCH=4, SELW=3)
module tb_mux_arb;
  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int SELW  = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH-1:0]       in_vld;
  logic [NCH*WIDTH-1:0] in_dat;
  logic [NCH-1:0]       in_rdy;
  logic                 out_vld;
  logic [WIDTH-1:0]     out_dat;
  logic [SELW-1:0]      out_ch;
  logic                 out_rdy;
`ifdef MUX_ARB_PKT_LOCK_EN
  logic [NCH-1:0]       in_lst;
  logic                 out_lst;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int sent    = 0;
  int rcv     = 0;

  always #5 clk = ~clk;

  mux_arb #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_vld(in_vld), .in_dat(in_dat), .in_rdy(in_rdy),
`ifdef MUX_ARB_PKT_LOCK_EN
    .in_lst(in_lst), .out_lst(out_lst),
`endif
    .out_vld(out_vld), .out_dat(out_dat), .out_ch(out_ch), .out_rdy(out_rdy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    mode    = 1'b1;
    sel     = '0;
    in_vld  = 4'b1111;
    out_rdy = 1'b1;
    for (int i = 0; i < NCH; i++) in_dat[i*WIDTH +: WIDTH] = 32'hA0 + i;
`ifdef MUX_ARB_PKT_LOCK_EN
    in_lst = '1;
`endif

    // reset state
    tick();
    check("rst_in_rdy", in_rdy, 0);
    tick();
    check("rst_out_vld", out_vld, 0);
    check("rst_out_dat", out_dat, 0);
    check("rst_out_ch", out_ch, 0);
    rst = 1'b0;

    // round robin over all-valid channels
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_out_vld", out_vld, 1);
      check("rr_out_ch", out_ch, k % 4);
      check("rr_out_dat", out_dat, 32'hA0 + (k % 4));
    end

    // external select
    mode = 1'b0;
    sel  = 3'd2;
    #1 check("sel2_in_rdy", in_rdy, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("sel2_out_ch", out_ch, 2);
      check("sel2_out_dat", out_dat, 32'hA2);
      #1 check("sel2_in_rdy_hold", in_rdy, 4'b0100);
    end
    sel = 3'd5;
    #1 check("sel5_in_rdy", in_rdy, 0);
    tick();
    check("sel5_out_vld", out_vld, 0);
    check("sel5_out_ch_hold", out_ch, 2);

    // backpressure, ptr=0 so ch1 wins first
    mode   = 1'b1;
    in_vld = 4'b1010;
    #1 check("bp_first_rdy", in_rdy, 4'b0010);
    tick();
    check("bp_first_ch", out_ch, 1);
    out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_in_rdy", in_rdy, 0);
      tick();
      check("bp_out_vld", out_vld, 1);
      check("bp_out_ch", out_ch, 1);
      check("bp_out_dat", out_dat, 32'hA1);
    end
    out_rdy = 1'b1;
    #1 check("bp_release_rdy", in_rdy, 4'b1000);
    tick();
    check("bp_next_ch3", out_ch, 3);
    tick();
    check("bp_next_ch1", out_ch, 1);

    // drain, then toggled out_rdy with one channel streaming 100 beats
    in_vld = 4'b0000;
    tick();
    check("drain_out_vld", out_vld, 0);
    in_vld = 4'b0100;
    in_dat[2*WIDTH +: WIDTH] = 32'h1000;
    for (int c = 0; c < 200; c++) begin
      out_rdy = (c % 2 == 0);
      #1;
      check("tog_in_rdy", in_rdy, (c % 2 == 0) ? 4'b0100 : 4'b0000);
      if (out_vld && out_rdy) begin
        check("tog_out_dat", out_dat, 32'h1000 + rcv);
        rcv++;
      end
      if (in_rdy[2]) sent++;
      tick();
      in_dat[2*WIDTH +: WIDTH] = 32'h1000 + sent;
    end
    in_vld  = 4'b0000;
    out_rdy = 1'b1;
    #1;
    if (out_vld) begin
      check("tog_out_dat_last", out_dat, 32'h1000 + rcv);
      rcv++;
    end
    tick();
    check("tog_sent", sent, 100);
    check("tog_rcv", rcv, 100);

    // reset while holding a beat with ptr=2
    for (int i = 0; i < NCH; i++) in_dat[i*WIDTH +: WIDTH] = 32'hA0 + i;
    in_vld = 4'b0100;
    tick();
    check("mid_pre_ch", out_ch, 2);
    check("mid_pre_vld", out_vld, 1);
    rst    = 1'b1;
    in_vld = 4'b1111;
    #1 check("mid_rst_in_rdy", in_rdy, 0);
    tick();
    check("mid_out_vld", out_vld, 0);
    check("mid_out_dat", out_dat, 0);
    check("mid_out_ch", out_ch, 0);
    rst = 1'b0;
    tick();
    check("mid_first_ch", out_ch, 0);
    check("mid_first_vld", out_vld, 1);

`ifdef MUX_ARB_PKT_LOCK_EN
    // ptr=0: ch1 starts a 3-beat packet while ch0/ch2 are valid
    in_vld = 4'b0111;
    in_lst = 4'b1101;
    tick();
    check("lock_b0_ch", out_ch, 1);
    check("lock_b0_lst", out_lst, 0);
    tick();
    check("lock_b1_ch", out_ch, 1);
    check("lock_b1_lst", out_lst, 0);
    in_lst = 4'b1111;
    tick();
    check("lock_b2_ch", out_ch, 1);
    check("lock_b2_lst", out_lst, 1);
    tick();
    check("lock_after_ch", out_ch, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
